// File: rtl/mem_io_bridge.sv
// Purpose: byte-bus bridge from the CPU to a synchronous RAM and memory-mapped I/O (UART TX FIFO, RX pop, cycle counter, halt).
// Latency: read data reaches cpu_din exactly one cycle after the address. Writes take effect at the clock edge that ends the access cycle.
// Backpressure: the UART drains the TX FIFO through tx_valid/tx_ready. The CPU sees io_buffer_full, and a push to a full FIFO is dropped.
//
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in        clock, reset, CPU ready
//   cpu_a, cpu_dout, cpu_wr -> cpu_din                CPU byte bus
//   io_buffer_full                                    TX FIFO near-full flag to the CPU
//   ram_a, ram_we, ram_wdata, ram_rdata               synchronous RAM; read data arrives the cycle after ram_a
//   tx_data, tx_valid, tx_ready                       UART transmit stream
//   rx_data, rx_empty -> rx_pop                       UART receive queue head and pop strobe
//   halt                                              sticky program-stop flag
// Optional build macro BRIDGE_ADDR_CHECK_EN adds the sticky 'err' output and
// blocks RAM writes to the unpopulated 0x20000..0x2FFFF window.

module mem_io_bridge #(
    parameter int TX_DEPTH    = 16,
    parameter int FULL_MARGIN = 2,
    parameter int RAM_AW      = 17
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic [31:0]       cpu_a,
    input  logic [7:0]        cpu_dout,
    input  logic              cpu_wr,
    output logic [7:0]        cpu_din,
    output logic              io_buffer_full,
    output logic [RAM_AW-1:0] ram_a,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_empty,
    output logic              rx_pop,
    output logic              halt
`ifdef BRIDGE_ADDR_CHECK_EN
    ,
    output logic              err
`endif
);

    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(TX_DEPTH);
    localparam logic [CW-1:0] FULL_TH_C = CW'(TX_DEPTH - FULL_MARGIN);

    typedef enum logic {SEL_RAM, SEL_IO} sel_e;

    // Address decode
    logic        is_io;
    logic [15:0] io_off;
    logic        rd_acc;
    logic        wr_acc;
    logic        unused_addr_bits;

    assign is_io            = (cpu_a[17:16] == 2'b11);
    assign io_off           = cpu_a[15:0];
    assign rd_acc           = rdy_in & ~cpu_wr;
    assign wr_acc           = rdy_in & cpu_wr;
    assign unused_addr_bits = ^cpu_a[31:18];

    assign ram_a     = cpu_a[RAM_AW-1:0];
    assign ram_wdata = cpu_dout;

`ifdef BRIDGE_ADDR_CHECK_EN
    logic hi_ram;
    assign hi_ram = ~is_io & cpu_a[17];
    assign ram_we = wr_acc & ~is_io & ~hi_ram;
`else
    assign ram_we = wr_acc & ~is_io;
`endif

    // TX FIFO state
    logic [7:0]    fifo_mem [TX_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_q;

    logic       push_req, push, pop, fifo_full;
    logic [7:0] push_dat;
    logic       halt_wr;

    assign halt_wr   = wr_acc & is_io & (io_off == 16'h0004);
    assign push_req  = (wr_acc & is_io & (io_off == 16'h0000) & (cpu_dout != 8'h00)) | halt_wr;
    assign push_dat  = halt_wr ? 8'h00 : cpu_dout;
    assign tx_valid  = (cnt_q != '0);
    assign pop       = tx_valid & tx_ready;
    assign fifo_full = (cnt_q == DEPTH_C);
    // A same-cycle pop frees the head slot, so a full FIFO still accepts the push.
    assign push      = push_req & (~fifo_full | pop);

    // Gate the head with tx_valid so tx_data is 0 whenever the FIFO is empty, including during reset.
    assign tx_data        = tx_valid ? fifo_mem[rd_ptr_q] : 8'h00;
    assign io_buffer_full = full_q;

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (push) fifo_mem[wr_ptr_q] <= push_dat;
    end

    // Read path
    logic [31:0] cyc_q;
    logic [31:0] snap_q;
    logic [7:0]  dat_q;
    logic        rd_vld_q;
    sel_e        sel_q;
    logic        halt_q;
    logic        snap_ld;
    logic [7:0]  io_rdat;

    assign snap_ld = rd_acc & is_io & (io_off == 16'h0004);

    always_comb begin
        io_rdat = 8'h00;
        if (io_off == 16'h0000) begin
            io_rdat = rx_empty ? 8'h00 : rx_data;
        end else if (io_off[15:2] == 14'h0001) begin
            // Byte 0 comes from the live counter because the snapshot loads in this same cycle.
            io_rdat = (io_off[1:0] == 2'b00) ? cyc_q[7:0] : snap_q[8*io_off[1:0] +: 8];
        end
    end

    // RAM data passes straight through the cycle after a RAM read. In every
    // other case cpu_din comes from dat_q, which keeps the last value shown.
    assign cpu_din = (rd_vld_q && sel_q == SEL_RAM) ? ram_rdata : dat_q;

    // rx_pop is gated by reset so that it stays low while reset is asserted.
    assign rx_pop  = rst_in & rd_acc & is_io & (io_off == 16'h0000) & ~rx_empty;
    assign halt    = halt_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            cyc_q    <= 32'd0;
            snap_q   <= 32'd0;
            dat_q    <= 8'h00;
            rd_vld_q <= 1'b0;
            sel_q    <= SEL_RAM;
            halt_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            cnt_q  <= cnt_d;
            full_q <= (cnt_d >= FULL_TH_C);

            if (rdy_in) cyc_q <= cyc_q + 32'd1;
            if (snap_ld) snap_q <= cyc_q;
            if (halt_wr) halt_q <= 1'b1;

            if (rd_acc) begin
                rd_vld_q <= 1'b1;
                sel_q    <= is_io ? SEL_IO : SEL_RAM;
                if (is_io) dat_q <= io_rdat;
            end else begin
                rd_vld_q <= 1'b0;
                dat_q    <= cpu_din;
            end
        end
    end

`ifdef BRIDGE_ADDR_CHECK_EN
    logic err_q;
    assign err = err_q;
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            err_q <= 1'b0;
        end else if ((rdy_in & hi_ram) | (push_req & fifo_full & ~pop)) begin
            err_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_io_bridge.sv
// Purpose: self-checking bench for mem_io_bridge: directed scenarios followed by randomized traffic.
// Latency: each bus access takes one clock; outputs are sampled on the falling edge.
// Backpressure: the bench drives tx_ready and rx_empty itself.

module tb_mem_io_bridge;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic [16:0] ram_a;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_empty;
    logic        rx_pop;
    logic        halt;

    always #5 clk = ~clk;

    mem_io_bridge #(.TX_DEPTH(16), .FULL_MARGIN(2), .RAM_AW(17)) dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
        .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr), .cpu_din(cpu_din),
        .io_buffer_full(io_buffer_full),
        .ram_a(ram_a), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_empty(rx_empty), .rx_pop(rx_pop),
        .halt(halt)
    );

    // Synchronous RAM of the environment. Test addresses only use bits [5:0]
    // after truncation; ram_a itself is checked in full on every cycle.
    bit [7:0] ram [0:63];
    always @(posedge clk) begin
        if (ram_we) ram[ram_a[5:0]] <= ram_wdata;
        ram_rdata <= ram[ram_a[5:0]];
    end

    // Behavioural reference state
    bit [7:0]    ref_mem [64];
    logic [7:0]  q [$];
    logic [31:0] m_cnt, m_snap;
    logic [7:0]  m_din;
    bit          m_halt, m_full;

    logic [7:0]  obs_tx [$];
    bit          s_rx_pop, s_we, s_full;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        m_cnt  = 32'd0;
        m_snap = 32'd0;
        m_din  = 8'h00;
        m_halt = 1'b0;
        m_full = 1'b0;
    endtask

    // One bus cycle: drive the inputs at posedge+1, compare at the falling
    // edge, then advance the model past the next rising edge.
    task automatic cyc(input bit rdy, input bit wr, input logic [31:0] a, input logic [7:0] d,
                       input bit txr, input bit rxe, input logic [7:0] rxd);
        bit          io;
        logic [17:0] off;
        bit          e_we, e_pop, popd;
        logic [7:0]  tmp;
        rdy_in = rdy; cpu_wr = wr; cpu_a = a; cpu_dout = d;
        tx_ready = txr; rx_empty = rxe; rx_data = rxd;
        io    = (a[17:16] == 2'b11);
        off   = a[17:0];
        e_we  = rdy && wr && !io;
        e_pop = rdy && !wr && io && off == 18'h30000 && !rxe;
        #4;
        chk("ram_a", {15'd0, ram_a}, {15'd0, a[16:0]});
        chk("ram_we", {31'd0, ram_we}, {31'd0, e_we});
        if (e_we) chk("ram_wdata", {24'd0, ram_wdata}, {24'd0, d});
        chk("rx_pop", {31'd0, rx_pop}, {31'd0, e_pop});
        chk("cpu_din", {24'd0, cpu_din}, {24'd0, m_din});
        chk("tx_valid", {31'd0, tx_valid}, {31'd0, (q.size() != 0)});
        if (q.size() != 0) chk("tx_data", {24'd0, tx_data}, {24'd0, q[0]});
        chk("io_buffer_full", {31'd0, io_buffer_full}, {31'd0, m_full});
        chk("halt", {31'd0, halt}, {31'd0, m_halt});
        s_rx_pop = rx_pop; s_we = ram_we; s_full = io_buffer_full;
        if (tx_valid && tx_ready) obs_tx.push_back(tx_data);

        popd = (q.size() != 0) && txr;
        if (popd) tmp = q.pop_front();
        if (rdy && wr && io && ((off == 18'h30000 && d != 8'h00) || off == 18'h30004)) begin
            if (q.size() < 16) q.push_back((off == 18'h30004) ? 8'h00 : d);
        end
        if (rdy && wr && io && off == 18'h30004) m_halt = 1'b1;
        if (rdy && wr && !io) ref_mem[a[5:0]] = d;
        if (rdy && !wr) begin
            if (!io) m_din = ref_mem[a[5:0]];
            else if (off == 18'h30000) m_din = rxe ? 8'h00 : rxd;
            else if (off == 18'h30004) begin m_snap = m_cnt; m_din = m_cnt[7:0]; end
            else if (off >= 18'h30005 && off <= 18'h30007) m_din = 8'(m_snap >> (8 * (off - 18'h30004)));
            else m_din = 8'h00;
        end
        m_full = (q.size() >= 14);
        if (rdy) m_cnt = m_cnt + 32'd1;
        @(posedge clk); #1;
    endtask

    task automatic idle(input bit txr);
        cyc(1'b1, 1'b0, 32'h0, 8'h00, txr, 1'b1, 8'h00);
    endtask

    logic [31:0] io_tab [7];
    initial begin
        io_tab[0] = 32'h30000; io_tab[1] = 32'h30004; io_tab[2] = 32'h30005;
        io_tab[3] = 32'h30006; io_tab[4] = 32'h30007; io_tab[5] = 32'h30008;
        io_tab[6] = 32'h3FFFF;
    end

    initial begin
        logic [31:0] r, a;
        logic [7:0]  d;
        rst_in = 1'b0; rdy_in = 1'b0; cpu_a = 32'h0; cpu_dout = 8'h00; cpu_wr = 1'b0;
        tx_ready = 1'b0; rx_empty = 1'b1; rx_data = 8'h00;
        model_reset();
        #8;
        chk("rst_cpu_din", {24'd0, cpu_din}, 32'h0);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'h0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'h0);
        chk("rst_halt", {31'd0, halt}, 32'h0);
        chk("rst_full", {31'd0, io_buffer_full}, 32'h0);
        chk("rst_rx_pop", {31'd0, rx_pop}, 32'h0);
        @(posedge clk); #1;
        rst_in = 1'b1;

        // RAM write then read-back
        cyc(1'b1, 1'b1, 32'h10, 8'h5A, 1'b0, 1'b1, 8'h00);
        chk("lit_we", {31'd0, s_we}, 32'h1);
        cyc(1'b1, 1'b0, 32'h10, 8'h00, 1'b0, 1'b1, 8'h00);
        chk("lit_readback", {24'd0, cpu_din}, 32'h5A);

        // TX: a zero byte is dropped
        obs_tx.delete();
        cyc(1'b1, 1'b1, 32'h30000, 8'h41, 1'b1, 1'b1, 8'h00);
        cyc(1'b1, 1'b1, 32'h30000, 8'h00, 1'b1, 1'b1, 8'h00);
        cyc(1'b1, 1'b1, 32'h30000, 8'h42, 1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 3; i++) idle(1'b1);
        chk("lit_tx_n", obs_tx.size(), 32'd2);
        if (obs_tx.size() == 2) begin
            chk("lit_tx0", {24'd0, obs_tx[0]}, 32'h41);
            chk("lit_tx1", {24'd0, obs_tx[1]}, 32'h42);
        end
        chk("lit_tx_empty", {31'd0, tx_valid}, 32'h0);
        chk("lit_no_halt", {31'd0, halt}, 32'h0);

        // Fill the FIFO; the 17th push is dropped
        obs_tx.delete();
        for (int i = 1; i <= 14; i++) cyc(1'b1, 1'b1, 32'h30000, 8'(i), 1'b0, 1'b1, 8'h00);
        idle(1'b0);
        chk("lit_full", {31'd0, s_full}, 32'h1);
        for (int i = 15; i <= 17; i++) cyc(1'b1, 1'b1, 32'h30000, 8'(i), 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 20; i++) idle(1'b1);
        chk("lit_drain_n", obs_tx.size(), 32'd16);
        for (int i = 0; i < obs_tx.size() && i < 16; i++) chk("lit_drain_order", {24'd0, obs_tx[i]}, i + 1);

        // RX pop with a byte waiting, then with the queue empty
        cyc(1'b1, 1'b0, 32'h30000, 8'h00, 1'b0, 1'b0, 8'h37);
        chk("lit_rx_pop", {31'd0, s_rx_pop}, 32'h1);
        chk("lit_rx_din", {24'd0, cpu_din}, 32'h37);
        cyc(1'b1, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 8'h37);
        chk("lit_rx_single", {31'd0, s_rx_pop}, 32'h0);
        cyc(1'b1, 1'b0, 32'h30000, 8'h00, 1'b0, 1'b1, 8'h37);
        chk("lit_rx_nopop", {31'd0, s_rx_pop}, 32'h0);
        chk("lit_rx_zero", {24'd0, cpu_din}, 32'h0);

        // Halt with three bytes queued, then an asynchronous reset mid-drain
        cyc(1'b1, 1'b1, 32'h30000, 8'h11, 1'b0, 1'b1, 8'h00);
        cyc(1'b1, 1'b1, 32'h30000, 8'h22, 1'b0, 1'b1, 8'h00);
        cyc(1'b1, 1'b1, 32'h30000, 8'h33, 1'b0, 1'b1, 8'h00);
        cyc(1'b1, 1'b1, 32'h30004, 8'h99, 1'b0, 1'b1, 8'h00);
        chk("lit_halt", {31'd0, halt}, 32'h1);
        for (int i = 0; i < 3; i++) idle(1'b1);
        chk("lit_last_valid", {31'd0, tx_valid}, 32'h1);
        chk("lit_last_zero", {24'd0, tx_data}, 32'h0);
        rdy_in = 1'b0; tx_ready = 1'b0;
        #2 rst_in = 1'b0;
        #1;
        chk("async_tx_valid", {31'd0, tx_valid}, 32'h0);
        chk("async_halt", {31'd0, halt}, 32'h0);
        model_reset();
        @(posedge clk); #1;
        rst_in = 1'b1;

        // Snapshot stays consistent while the counter moves on
        for (int i = 0; i < 600 && m_cnt != 32'h1FF; i++) idle(1'b0);
        chk("lit_cnt_reach", m_cnt, 32'h1FF);
        cyc(1'b1, 1'b0, 32'h30004, 8'h00, 1'b0, 1'b1, 8'h00);
        chk("lit_snap0", {24'd0, cpu_din}, 32'hFF);
        cyc(1'b1, 1'b0, 32'h30005, 8'h00, 1'b0, 1'b1, 8'h00);
        chk("lit_snap1", {24'd0, cpu_din}, 32'h01);
        cyc(1'b1, 1'b0, 32'h30006, 8'h00, 1'b0, 1'b1, 8'h00);
        chk("lit_snap2", {24'd0, cpu_din}, 32'h00);
        cyc(1'b1, 1'b0, 32'h30007, 8'h00, 1'b0, 1'b1, 8'h00);
        chk("lit_snap3", {24'd0, cpu_din}, 32'h00);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            r = $urandom();
            if (($urandom() % 3) == 0) begin
                a = io_tab[$urandom_range(0, 6)];
            end else begin
                a = (r & 32'hFFFC_0000) | (32'($urandom_range(0, 1)) << 17) | 32'($urandom_range(0, 63));
            end
            d = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom());
            cyc(($urandom_range(0, 4) != 0), $urandom_range(0, 1) == 1, a, d,
                $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, 8'($urandom()));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_io_bridge.md
Name: mem_io_bridge

Overview:
- Sits directly downstream of the CPU top's byte-wide memory bus (mem_a/mem_dout/mem_wr/mem_din/io_buffer_full).
- Routes each access to the 128 KB synchronous RAM or to memory-mapped I/O.
- Holds a UART TX FIFO, an RX pop path and the running cycle counter; raises halt on program stop.
- Returns read data exactly one cycle after the address is presented, which is the contract the CPU's memory controller depends on.

Parameters:
- TX_DEPTH, 16, TX FIFO entries (power of 2, ≥4)
- FULL_MARGIN, 2, free entries remaining when io_buffer_full asserts
- RAM_AW, 17, RAM address width (byte address)

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset; asynchronous, active-low
- rdy_in  in  1  CPU ready; bus accesses and counter honoured only when high
- cpu_a  in  32  CPU address (mem_a)
- cpu_dout  in  8  CPU write byte (mem_dout)
- cpu_wr  in  1  1 = write, 0 = read
- cpu_din  out  8  read byte to CPU (mem_din)
- io_buffer_full  out  1  TX FIFO near-full to CPU
- ram_a  out  RAM_AW  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  8  RAM write byte
- ram_rdata  in  8  RAM read byte, valid one cycle after ram_a
- tx_data  out  8  byte to UART transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART accepts byte this cycle
- rx_data  in  8  head byte of UART receive queue
- rx_empty  in  1  receive queue empty
- rx_pop  out  1  one-cycle pop of receive queue
- halt  out  1  sticky program-stop flag

Behaviour:
- Decode: io = cpu_a[17:16]==2'b11; otherwise RAM. ram_a = cpu_a[RAM_AW-1:0] combinationally. ram_we = rdy_in & cpu_wr & ~io.
- Reset (rst_in low, async): cpu_din=0, rx_pop=0, tx_valid=0, tx_data=0, halt=0, io_buffer_full=0, FIFO empty, cycle counter=0, snapshot=0, sel=RAM.
- Cycle counter: 32-bit, +1 each clk_in while rdy_in high, wraps at 0xFFFFFFFF→0.
- Read latency is 1 cycle. In cycle N, when rdy_in is high and cpu_wr=0, register sel from the address:
  - RAM: cpu_din = ram_rdata in N+1.
  - 0x30000: cpu_din = rx_empty ? 0x00 : rx_data, registered in N. rx_pop pulses in N only if not empty.
  - 0x30004..0x30007: byte k of the snapshot (little-endian). A read of 0x30004 loads the snapshot from the live counter in N and returns byte 0 of the new value, giving the CPU a consistent dword.
  - Other IO offsets: cpu_din = 0x00.
- When rdy_in is low: no RAM write, no FIFO push, no rx_pop, cpu_din holds.
- IO writes (rdy_in high, cpu_wr=1):
  - 0x30000 with cpu_dout≠0: push into TX FIFO. A write of 0x00 is dropped.
  - 0x30004: push 0x00 and set halt (sticky until reset).
  - A push to a full FIFO is dropped; the CPU is responsible for honouring io_buffer_full.
- TX FIFO:
  - Circular with wrap-around pointers plus a count of log2(TX_DEPTH)+1 bits.
  - tx_valid = count≠0; tx_data = head entry.
  - A pop occurs when tx_valid & tx_ready.
  - A simultaneous push and pop leaves count unchanged, and the new data is stored correctly even when count==1 or count==TX_DEPTH (the pop frees a slot first).
- io_buffer_full: registered; 1 when next-cycle count ≥ TX_DEPTH-FULL_MARGIN.
- Halt does not block draining: the FIFO keeps emptying to the UART after halt.

Optional Feature:
- BRIDGE_ADDR_CHECK_EN.
- When defined: extra output err (1 bit, reset 0). It is set sticky when rdy_in is high and the address is non-IO with cpu_a[17:0] ≥ 0x20000, or when a push hits a full FIFO. A RAM write in the 0x20000..0x2FFFF range is suppressed (ram_we=0).
- When undefined: no err port, no suppression; RAM address simply truncates.

Test Plan:
- Reset, then write 0x5A to 0x00010 and read it back → ram_we=1 in the write cycle; cpu_din=0x5A one cycle after the read address.
- Write 0x41, 0x00, 0x42 to 0x30000 with tx_ready=1 → tx_data sequence 0x41, 0x42 only; FIFO ends empty; halt=0.
- Hold tx_ready=0 and push 14 bytes (TX_DEPTH=16) → io_buffer_full=1 by the cycle after the 14th push. A 17th push is dropped; after tx_ready=1, exactly 16 bytes emerge in order.
- Counter at 0x000001FF; read 0x30004 through 0x30007 on consecutive cycles → cpu_din = 0xFF, 0x01, 0x00, 0x00, with no tearing from the counter advancing.
- rx_empty=0, rx_data=0x37; read 0x30000 → rx_pop single pulse; cpu_din=0x37 next cycle. Repeat with rx_empty=1 → no pop, cpu_din=0x00.
- Write to 0x30004 while FIFO holds 3 bytes, then drop rst_in mid-drain → halt=1 and 0x00 queued last. On asynchronous reset, tx_valid and halt clear immediately without waiting for a clock edge.
